jedro_1_run_checker: RTL and testbench
======================================

Name: jedro_1_run_checker

Overview:
Synthesizable run-and-check controller for jedro_1 program tests.
- Holds the core in reset, releases it, and counts cycles until the core halts on an illegal instruction or a timeout expires.
- Lets the pipeline drain, then compares a parametrised table of register/expected-value pairs through a regfile read port and reports pass/fail.
- Sits beside jedro_1_top in self-checking benches and FPGA smoke tests, replacing per-test hand-written checks.

Parameters:
DATA_WIDTH, 32, register data width
REG_ADDR_WIDTH, 5, regfile address width
NUM_CHECKS, 8, entries in the expected-value table (>=1)
RESET_CYCLES, 3, cycles core_rstn_o is held low after start
DRAIN_CYCLES, 3, cycles waited after halt/timeout before checking
TIMEOUT_CYCLES, 32, max RUN cycles (>=1)
CNT_WIDTH, 16, width of cycle counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  begin a run; sampled only in IDLE/DONE
halt_i  in  1  core illegal-instruction flag (decoder illegal_instr)
exp_addr_i  in  NUM_CHECKS*REG_ADDR_WIDTH  packed register indices, entry 0 in LSBs
exp_data_i  in  NUM_CHECKS*DATA_WIDTH  packed expected values, entry 0 in LSBs
rf_raddr_o  out  REG_ADDR_WIDTH  regfile read address
rf_rdata_i  in  DATA_WIDTH  regfile read data, combinational from rf_raddr_o
core_rstn_o  out  1  active-low reset to core
busy_o  out  1  run in progress
done_o  out  1  results valid
pass_o  out  1  all checks matched
timeout_o  out  1  RUN ended by timeout, not halt
fail_cnt_o  out  $clog2(NUM_CHECKS+1)  number of mismatches
first_fail_idx_o  out  $clog2(NUM_CHECKS) (min 1)  index of first mismatch
first_fail_data_o  out  DATA_WIDTH  actual value read at first mismatch
cycle_cnt_o  out  CNT_WIDTH  RUN cycles counted

Behaviour:
- Reset values:
  - All outputs 0; core_rstn_o=0, so the core is held in reset.
  - FSM=IDLE.
  - rst_i is asynchronous and can assert at any point; mid-run it aborts immediately to these values.
- States: IDLE, RESET, RUN, DRAIN, CHECK, DONE.
- IDLE/DONE + start_i=1:
  - Clear done, pass, timeout, fail_cnt, first_fail_*, cycle_cnt; busy_o=1; go to RESET.
  - start_i is ignored in every other state.
- RESET: core_rstn_o=0 for exactly RESET_CYCLES cycles, then RUN.
- RUN:
  - core_rstn_o=1; cycle_cnt increments every cycle and saturates at all-ones.
  - halt_i=1 at a posedge -> DRAIN.
  - Otherwise, the cycle when cycle_cnt reaches TIMEOUT_CYCLES -> DRAIN with timeout_o=1.
  - halt_i and timeout in the same cycle -> treated as halt, timeout_o=0.
- DRAIN: core_rstn_o stays 1 for DRAIN_CYCLES cycles, then CHECK with idx=0.
- CHECK:
  - One entry per cycle: rf_raddr_o = exp_addr[idx]; compare rf_rdata_i with exp_data[idx] at the posedge.
  - On mismatch: fail_cnt++; if this is the first mismatch, capture idx into first_fail_idx and rf_rdata_i into first_fail_data.
  - After idx=NUM_CHECKS-1 -> DONE. CHECK lasts exactly NUM_CHECKS cycles.
  - core_rstn_o=0 on entry to CHECK, freezing the core so regfile values are stable.
- DONE:
  - done_o=1, busy_o=0, pass_o = (fail_cnt==0).
  - Timeout is not a failure; it is reported separately on timeout_o.
  - Stays in DONE until start_i or rst_i.
- rf_raddr_o=0 outside CHECK.

Optional Feature:
JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
- Defined: adds output fail_mask_o [NUM_CHECKS]. Bit i is set when entry i mismatches; cleared on start and on reset.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- add program, NUM_CHECKS=5, entries (x1,2),(x2,2),(x3,2),(x4,2),(x10,3), halt after 12 RUN cycles -> done_o=1, pass_o=1, fail_cnt_o=0, timeout_o=0, cycle_cnt_o=12.
- Same run with entry 4 expecting x10=4 while the core holds 3 -> pass_o=0, fail_cnt_o=1, first_fail_idx_o=4, first_fail_data_o=3; with macro, fail_mask_o=5'b10000.
- halt_i never asserted, TIMEOUT_CYCLES=32 -> timeout_o=1, cycle_cnt_o=32; DONE reached exactly RESET_CYCLES+32+DRAIN_CYCLES+NUM_CHECKS cycles after start.
- halt_i asserted on the same cycle the timeout would fire -> timeout_o=0.
- rst_i pulsed mid-RUN -> all outputs 0 and core_rstn_o=0 immediately; start_i then restarts cleanly from RESET.
- Entries 1 and 3 mismatch -> fail_cnt_o=2, first_fail_idx_o=1; start_i pulsed during RUN is ignored; start_i in DONE clears all results.

Source files
------------

// File: rtl/jedro_1_run_checker.sv
// Run-and-check controller: holds the core in reset, runs it to halt or timeout, drains, then checks a register table.
// Optional JEDRO_1_RUN_CHECKER_FAIL_MASK_EN adds fail_mask_o, a per-entry mismatch flag vector.
module jedro_1_run_checker #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_CHECKS     = 8,
  parameter int RESET_CYCLES   = 3,
  parameter int DRAIN_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int CNT_WIDTH      = 16,
  localparam int FCW  = $clog2(NUM_CHECKS + 1),
  localparam int IDXW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
  output logic [NUM_CHECKS-1:0]                fail_mask_o,
`endif
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 halt_i,
  input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] exp_addr_i,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     exp_data_i,
  output logic [REG_ADDR_WIDTH-1:0]            rf_raddr_o,
  input  logic [DATA_WIDTH-1:0]                rf_rdata_i,
  output logic                                 core_rstn_o,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 timeout_o,
  output logic [FCW-1:0]                       fail_cnt_o,
  output logic [IDXW-1:0]                      first_fail_idx_o,
  output logic [DATA_WIDTH-1:0]                first_fail_data_o,
  output logic [CNT_WIDTH-1:0]                 cycle_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  // One phase counter serves both the RESET and DRAIN waits.
  localparam int PMAX = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
  localparam int PCW  = (PMAX > 1) ? $clog2(PMAX) : 1;
  localparam logic [PCW-1:0]  RESET_LAST = PCW'(RESET_CYCLES - 1);
  localparam logic [PCW-1:0]  DRAIN_LAST = PCW'(DRAIN_CYCLES - 1);
  localparam logic [IDXW-1:0] IDX_LAST   = IDXW'(NUM_CHECKS - 1);
  localparam logic [CNT_WIDTH:0] TIMEOUT_EXT = (CNT_WIDTH + 1)'(TIMEOUT_CYCLES);

  state_t                  state;
  logic [PCW-1:0]          phase;
  logic [IDXW-1:0]         idx;
  logic [CNT_WIDTH:0]      cnt_plus1;
  logic [CNT_WIDTH-1:0]    cnt_next;
  logic                    timeout_hit;
  logic                    mismatch;

  // Extra carry bit gives saturation detection and the timeout match in one adder.
  assign cnt_plus1   = {1'b0, cycle_cnt_o} + {{CNT_WIDTH{1'b0}}, 1'b1};
  assign cnt_next    = cnt_plus1[CNT_WIDTH] ? cycle_cnt_o : cnt_plus1[CNT_WIDTH-1:0];
  assign timeout_hit = (cnt_plus1 == TIMEOUT_EXT);

  assign rf_raddr_o = (state == S_CHECK) ? exp_addr_i[int'(idx)*REG_ADDR_WIDTH +: REG_ADDR_WIDTH]
                                         : '0;
  assign mismatch   = (rf_rdata_i != exp_data_i[int'(idx)*DATA_WIDTH +: DATA_WIDTH]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= S_IDLE;
      phase             <= '0;
      idx               <= '0;
      core_rstn_o       <= 1'b0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      pass_o            <= 1'b0;
      timeout_o         <= 1'b0;
      fail_cnt_o        <= '0;
      first_fail_idx_o  <= '0;
      first_fail_data_o <= '0;
      cycle_cnt_o       <= '0;
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
      fail_mask_o       <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state             <= S_RESET;
            phase             <= '0;
            idx               <= '0;
            core_rstn_o       <= 1'b0;
            busy_o            <= 1'b1;
            done_o            <= 1'b0;
            pass_o            <= 1'b0;
            timeout_o         <= 1'b0;
            fail_cnt_o        <= '0;
            first_fail_idx_o  <= '0;
            first_fail_data_o <= '0;
            cycle_cnt_o       <= '0;
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
            fail_mask_o       <= '0;
`endif
          end
        end
        S_RESET: begin
          if (phase == RESET_LAST) begin
            phase       <= '0;
            core_rstn_o <= 1'b1;
            state       <= S_RUN;
          end else begin
            phase <= phase + PCW'(1);
          end
        end
        S_RUN: begin
          cycle_cnt_o <= cnt_next;
          // Halt wins over a simultaneous timeout.
          if (halt_i) begin
            state <= S_DRAIN;
          end else if (timeout_hit) begin
            timeout_o <= 1'b1;
            state     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (phase == DRAIN_LAST) begin
            phase       <= '0;
            idx         <= '0;
            core_rstn_o <= 1'b0;
            state       <= S_CHECK;
          end else begin
            phase <= phase + PCW'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            fail_cnt_o <= fail_cnt_o + FCW'(1);
            if (fail_cnt_o == '0) begin
              first_fail_idx_o  <= idx;
              first_fail_data_o <= rf_rdata_i;
            end
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
            fail_mask_o[idx] <= 1'b1;
`endif
          end
          if (idx == IDX_LAST) begin
            idx    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b1;
            pass_o <= (fail_cnt_o == '0) && !mismatch;
            state  <= S_DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jedro_1_run_checker.sv
// Self-checking bench for jedro_1_run_checker with a regfile array and a table-level reference model.
module tb_jedro_1_run_checker;
  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int NC  = 5;
  localparam int RC  = 3;
  localparam int DC  = 3;
  localparam int TO  = 32;
  localparam int CW  = 16;
  localparam int FCW = $clog2(NC + 1);
  localparam int IW  = (NC > 1) ? $clog2(NC) : 1;
  localparam int VW  = 5 + FCW + IW + DW + CW;

  logic              clk_i = 1'b0;
  logic              rst_i, start_i, halt_i;
  logic [NC*AW-1:0]  exp_addr_i;
  logic [NC*DW-1:0]  exp_data_i;
  logic [AW-1:0]     rf_raddr_o;
  logic [DW-1:0]     rf_rdata_i;
  logic              core_rstn_o, busy_o, done_o, pass_o, timeout_o;
  logic [FCW-1:0]    fail_cnt_o;
  logic [IW-1:0]     first_fail_idx_o;
  logic [DW-1:0]     first_fail_data_o;
  logic [CW-1:0]     cycle_cnt_o;
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
  logic [NC-1:0]     fail_mask_o;
`endif

  logic [DW-1:0] rf [32];
  logic [AW-1:0] tab_addr [NC];
  logic [DW-1:0] tab_data [NC];

  int tests = 0;
  int fails = 0;

  // Reference-model results
  logic [VW-1:0] exp_vec;
  logic [NC-1:0] exp_mask;
  int            exp_cyc, exp_done_n, exp_nf, exp_first;
  logic [DW-1:0] exp_fd;
  logic          exp_tmo;
  // Observations from the last run
  logic [VW-1:0] obs_vec;
  int            obs_done_n, rstn_err, busy_err;

  jedro_1_run_checker #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .NUM_CHECKS(NC), .RESET_CYCLES(RC),
    .DRAIN_CYCLES(DC), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
    .fail_mask_o(fail_mask_o),
`endif
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
    .exp_addr_i(exp_addr_i), .exp_data_i(exp_data_i),
    .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .core_rstn_o(core_rstn_o), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
    .timeout_o(timeout_o), .fail_cnt_o(fail_cnt_o), .first_fail_idx_o(first_fail_idx_o),
    .first_fail_data_o(first_fail_data_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  assign rf_rdata_i = rf[rf_raddr_o];

  function automatic logic [VW-1:0] cur_vec();
    return {done_o, busy_o, core_rstn_o, pass_o, timeout_o, fail_cnt_o,
            first_fail_idx_o, first_fail_data_o, cycle_cnt_o};
  endfunction

  task automatic load_tables();
    for (int i = 0; i < NC; i++) begin
      exp_addr_i[i*AW +: AW] = tab_addr[i];
      exp_data_i[i*DW +: DW] = tab_data[i];
    end
  endtask

  // Expected results from the table rules: h = halt RUN cycle, 0 = never.
  task automatic model(input int h);
    logic [DW-1:0] act;
    exp_nf = 0; exp_first = 0; exp_fd = '0; exp_mask = '0;
    for (int i = 0; i < NC; i++) begin
      act = rf[tab_addr[i]];
      if (act !== tab_data[i]) begin
        if (exp_nf == 0) begin exp_first = i; exp_fd = act; end
        exp_nf++;
        exp_mask[i] = 1'b1;
      end
    end
    exp_tmo    = (h == 0) || (h > TO);
    exp_cyc    = exp_tmo ? TO : h;
    exp_done_n = RC + exp_cyc + DC + NC;
    exp_vec    = {1'b1, 1'b0, 1'b0, (exp_nf == 0), exp_tmo, FCW'(exp_nf),
                  IW'(exp_first), exp_fd, CW'(exp_cyc)};
  endtask

  task automatic set_add_program();
    rf[0] = '0;
    for (int i = 1; i < 32; i++) rf[i] = 32'hdead_0000 + i;
    rf[1] = 2; rf[2] = 2; rf[3] = 2; rf[4] = 2; rf[10] = 3;
    tab_addr[0] = 1; tab_addr[1] = 2; tab_addr[2] = 3; tab_addr[3] = 4; tab_addr[4] = 10;
    tab_data[0] = 2; tab_data[1] = 2; tab_data[2] = 2; tab_data[3] = 2; tab_data[4] = 3;
  endtask

  // Drives one run; n counts falling edges after the start edge.
  task automatic do_run(input int h, input int start_at);
    int n;
    logic in_run;
    load_tables();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    n = 0; obs_done_n = -1; rstn_err = 0; busy_err = 0;
    while (n < 200) begin
      if (done_o === 1'b1) begin obs_done_n = n; break; end
      if (core_rstn_o !== (n >= RC && n < RC + exp_cyc + DC)) rstn_err++;
      if (busy_o !== 1'b1) busy_err++;
      in_run = (n >= RC && n < RC + exp_cyc);
      // halt_i noise outside RUN must be ignored
      halt_i  = (h > 0 && n == h + RC - 1) ? 1'b1 :
                (in_run ? 1'b0 : 1'($urandom_range(0, 1)));
      start_i = (n == start_at);
      @(negedge clk_i); n++;
    end
    halt_i = 1'b0; start_i = 1'b0;
    obs_vec = cur_vec();
  endtask

  task automatic test_reset();
    rst_i = 1'b1; start_i = 1'b0; halt_i = 1'b0;
    set_add_program(); load_tables();
    repeat (3) @(negedge clk_i);
    tests++;
    if ({cur_vec(), rf_raddr_o} !== '0) begin
      fails++; $display("FAIL reset_state got %h exp 0", {cur_vec(), rf_raddr_o});
    end
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    tests++;
    if (cur_vec() !== '0) begin fails++; $display("FAIL idle_no_start got %h exp 0", cur_vec()); end
  endtask

  task automatic test_add_program();
    set_add_program(); model(12); do_run(12, -1);
    tests++;
    if (obs_vec !== exp_vec) begin fails++; $display("FAIL add_results got %h exp %h", obs_vec, exp_vec); end
    tests++;
    if (cycle_cnt_o !== CW'(12) || pass_o !== 1'b1) begin
      fails++; $display("FAIL add_cycles got cnt=%0d pass=%b exp cnt=12 pass=1", cycle_cnt_o, pass_o);
    end
    tests++;
    if (obs_done_n !== exp_done_n) begin fails++; $display("FAIL add_latency got %0d exp %0d", obs_done_n, exp_done_n); end
    tests++;
    if (rstn_err + busy_err !== 0) begin
      fails++; $display("FAIL add_rstn_busy got rstn_err=%0d busy_err=%0d exp 0", rstn_err, busy_err);
    end
  endtask

  task automatic test_single_mismatch();
    set_add_program(); tab_data[4] = 4; model(12); do_run(12, -1);
    tests++;
    if (obs_vec !== exp_vec) begin fails++; $display("FAIL mis1_results got %h exp %h", obs_vec, exp_vec); end
    tests++;
    if (pass_o !== 1'b0 || fail_cnt_o !== FCW'(1) || first_fail_idx_o !== IW'(4) || first_fail_data_o !== 32'd3) begin
      fails++; $display("FAIL mis1_fields got pass=%b cnt=%0d idx=%0d data=%0d exp 0/1/4/3",
                        pass_o, fail_cnt_o, first_fail_idx_o, first_fail_data_o);
    end
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
    tests++;
    if (fail_mask_o !== 5'b10000) begin fails++; $display("FAIL mis1_mask got %b exp 10000", fail_mask_o); end
`endif
  endtask

  task automatic test_timeout();
    set_add_program(); model(0); do_run(0, -1);
    tests++;
    if (timeout_o !== 1'b1 || cycle_cnt_o !== CW'(TO)) begin
      fails++; $display("FAIL timeout_flag got tmo=%b cnt=%0d exp tmo=1 cnt=%0d", timeout_o, cycle_cnt_o, TO);
    end
    tests++;
    if (obs_done_n !== RC + TO + DC + NC) begin
      fails++; $display("FAIL timeout_latency got %0d exp %0d", obs_done_n, RC + TO + DC + NC);
    end
    tests++;
    if (obs_vec !== exp_vec || rstn_err !== 0) begin
      fails++; $display("FAIL timeout_results got %h rstn_err=%0d exp %h", obs_vec, rstn_err, exp_vec);
    end
  endtask

  task automatic test_halt_at_timeout();
    set_add_program(); model(TO); do_run(TO, -1);
    tests++;
    if (timeout_o !== 1'b0 || cycle_cnt_o !== CW'(TO) || obs_vec !== exp_vec) begin
      fails++; $display("FAIL halt_vs_timeout got tmo=%b cnt=%0d vec=%h exp tmo=0 cnt=%0d vec=%h",
                        timeout_o, cycle_cnt_o, obs_vec, TO, exp_vec);
    end
  endtask

  task automatic test_mid_run_reset();
    set_add_program(); load_tables();
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    repeat (8) @(negedge clk_i);
    tests++;
    if (core_rstn_o !== 1'b1 || busy_o !== 1'b1 || cycle_cnt_o !== CW'(8 - RC)) begin
      fails++; $display("FAIL prereset_run got rstn=%b busy=%b cnt=%0d exp 1/1/%0d",
                        core_rstn_o, busy_o, cycle_cnt_o, 8 - RC);
    end
    #2 rst_i = 1'b1;
    #1;
    tests++;
    if ({cur_vec(), rf_raddr_o} !== '0) begin
      fails++; $display("FAIL midrun_reset got %h exp 0", {cur_vec(), rf_raddr_o});
    end
    @(negedge clk_i); rst_i = 1'b0;
    model(12); do_run(12, -1);
    tests++;
    if (obs_vec !== exp_vec || obs_done_n !== exp_done_n || rstn_err !== 0) begin
      fails++; $display("FAIL restart_after_reset got %h n=%0d rstn_err=%0d exp %h n=%0d",
                        obs_vec, obs_done_n, rstn_err, exp_vec, exp_done_n);
    end
  endtask

  task automatic test_two_mismatch_restart();
    int k;
    set_add_program(); tab_data[1] = 5; tab_data[3] = 7; model(20);
    do_run(20, 10);  // start pulse during RUN must be ignored
    tests++;
    if (fail_cnt_o !== FCW'(2) || first_fail_idx_o !== IW'(1) || first_fail_data_o !== 32'd2) begin
      fails++; $display("FAIL mis2_fields got cnt=%0d idx=%0d data=%0d exp 2/1/2",
                        fail_cnt_o, first_fail_idx_o, first_fail_data_o);
    end
    tests++;
    if (obs_vec !== exp_vec || obs_done_n !== exp_done_n) begin
      fails++; $display("FAIL mis2_start_ignored got %h n=%0d exp %h n=%0d", obs_vec, obs_done_n, exp_vec, exp_done_n);
    end
    @(negedge clk_i); start_i = 1'b1;
    @(negedge clk_i); start_i = 1'b0;
    tests++;
    if (cur_vec() !== {1'b0, 1'b1, {(VW-2){1'b0}}}) begin
      fails++; $display("FAIL restart_clear got %h exp %h", cur_vec(), {1'b0, 1'b1, {(VW-2){1'b0}}});
    end
    k = 0;
    while (done_o !== 1'b1 && k < 200) begin @(negedge clk_i); k++; end
    tests++;
    if (done_o !== 1'b1) begin fails++; $display("FAIL restart_done got done=%b exp 1 within 200", done_o); end
  endtask

  task automatic test_random();
    int h;
    for (int it = 0; it < 20; it++) begin
      rf[0] = '0;
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < NC; i++) begin
        tab_addr[i] = AW'($urandom_range(0, 31));
        tab_data[i] = ($urandom_range(0, 2) == 0) ? DW'($urandom) : rf[tab_addr[i]];
      end
      h = $urandom_range(0, 40);
      model(h);
      do_run(h, $urandom_range(1, exp_done_n - 1));
      tests++;
      if (obs_vec !== exp_vec || obs_done_n !== exp_done_n || rstn_err + busy_err !== 0) begin
        fails++; $display("FAIL random_%0d got %h n=%0d rstn_err=%0d busy_err=%0d exp %h n=%0d",
                          it, obs_vec, obs_done_n, rstn_err, busy_err, exp_vec, exp_done_n);
      end
`ifdef JEDRO_1_RUN_CHECKER_FAIL_MASK_EN
      tests++;
      if (fail_mask_o !== exp_mask) begin
        fails++; $display("FAIL random_mask_%0d got %b exp %b", it, fail_mask_o, exp_mask);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_add_program();
    test_single_mismatch();
    test_timeout();
    test_halt_at_timeout();
    test_mid_run_reset();
    test_two_mismatch_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
